// File: rtl/mdu_if.sv
// Handshake and result bundle between the pipeline and the iterative
// multiply/divide unit. The pipeline side (master) issues operations and
// MTHI/MTLO writes; the unit side (slave) returns status and HI/LO.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_wen;
    logic             lo_wen;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, hi_wen, lo_wen, wdata,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b, hi_wen, lo_wen, wdata,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per clock on operand magnitudes, then a single fix-up
// cycle applies signs, special cases and writes HI/LO.
//   op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
// Latency is WIDTH+1 edges from the accepting edge to the done pulse.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    mdu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Two's-complement negation at operand width.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        neg_w = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation at double (product) width.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        neg_2w = ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [CW-1:0]      cnt_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   mcand_r;     // multiplicand magnitude, or divisor magnitude
    logic [2*WIDTH-1:0] acc_r;       // mult: {partial product, multiplier}; div: low half = dividend/quotient
    logic [WIDTH-1:0]   rem_r;       // settled remainder; always < divisor so WIDTH bits suffice
    logic               neg_a_r;
    logic               neg_b_r;
    logic               b_zero_r;
    logic [WIDTH-1:0]   a_orig_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;
    logic               dbz_r;

    logic               start_signed_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     div_shift_s;  // WIDTH+1-bit partial remainder before the trial subtract
    logic [WIDTH+1:0]   div_diff_s;
    logic               is_signed_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.div_by_zero = dbz_r;

    // Operand magnitudes for signed ops, raw operands for unsigned ops.
    always_comb begin
        start_signed_s = ~bus.op[0];
        if (start_signed_s && bus.a[WIDTH-1]) begin
            mag_a_s = neg_w(bus.a);
        end else begin
            mag_a_s = bus.a;
        end
        if (start_signed_s && bus.b[WIDTH-1]) begin
            mag_b_s = neg_w(bus.b);
        end else begin
            mag_b_s = bus.b;
        end
    end

    // One shift-add (multiply) or restoring shift-subtract (divide) step.
    always_comb begin
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
        div_shift_s = {rem_r, acc_r[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, mcand_r};
    end

    // Sign correction of the unsigned result applied in the fix-up cycle.
    always_comb begin
        is_signed_s = ~op_r[0];
        if (is_signed_s && (neg_a_r ^ neg_b_r)) begin
            prod_fix_s = neg_2w(acc_r);
            quo_fix_s  = neg_w(acc_r[WIDTH-1:0]);
        end else begin
            prod_fix_s = acc_r;
            quo_fix_s  = acc_r[WIDTH-1:0];
        end
        if (is_signed_s && neg_a_r) begin
            rem_fix_s = neg_w(rem_r);
        end else begin
            rem_fix_s = rem_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode: accept a start in IDLE, run WIDTH steps, one fix-up cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CW'(WIDTH - 1)) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath, HI/LO and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= '0;
            op_r     <= 2'b00;
            mcand_r  <= '0;
            acc_r    <= '0;
            rem_r    <= '0;
            neg_a_r  <= 1'b0;
            neg_b_r  <= 1'b0;
            b_zero_r <= 1'b0;
            a_orig_r <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // MT writes only land while idle; a start in the same
                    // cycle is still accepted and its result overwrites later.
                    if (bus.hi_wen) begin
                        hi_r <= bus.wdata;
                    end
                    if (bus.lo_wen) begin
                        lo_r <= bus.wdata;
                    end
                    if (bus.start) begin
                        busy_r   <= 1'b1;
                        cnt_r    <= '0;
                        op_r     <= bus.op;
                        neg_a_r  <= start_signed_s & bus.a[WIDTH-1];
                        neg_b_r  <= start_signed_s & bus.b[WIDTH-1];
                        b_zero_r <= (bus.b == '0);
                        a_orig_r <= bus.a;
                        rem_r    <= '0;
                        if (bus.op[1]) begin
                            mcand_r <= mag_b_s;
                            acc_r   <= {{WIDTH{1'b0}}, mag_a_s};
                        end else begin
                            mcand_r <= mag_a_s;
                            acc_r   <= {{WIDTH{1'b0}}, mag_b_s};
                        end
                    end
                end
                CALC: begin
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (op_r[1]) begin
                        if (!div_diff_s[WIDTH+1]) begin
                            rem_r <= div_diff_s[WIDTH-1:0];
                            acc_r <= {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_r <= div_shift_s[WIDTH-1:0];
                            acc_r <= {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_r <= mul_next_s;
                    end
                end
                FIX: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    if (!op_r[1]) begin
                        hi_r  <= prod_fix_s[2*WIDTH-1:WIDTH];
                        lo_r  <= prod_fix_s[WIDTH-1:0];
                        dbz_r <= 1'b0;
                    end else if (b_zero_r) begin
                        hi_r  <= a_orig_r;
                        lo_r  <= {WIDTH{1'b1}};
                        dbz_r <= 1'b1;
                    end else begin
                        // Most-negative / -1 yields magnitude 2^(WIDTH-1), which
                        // already reads back as the most-negative quotient.
                        hi_r  <= rem_fix_s;
                        lo_r  <= quo_fix_s;
                        dbz_r <= 1'b0;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter at WIDTH=32 and WIDTH=8. Expected results
// come from plain integer arithmetic on the operands' signed/unsigned values.
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mdu_if #(.WIDTH(32)) if32 ();
    mdu_if #(.WIDTH(8))  if8 ();

    mdu_iter #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));
    mdu_iter #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Reference: HI/LO/flag from signed or unsigned integer semantics.
    function automatic void ref_md(input int w, input logic [1:0] op,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] eh, output logic [31:0] el,
                                   output logic ed);
        logic [63:0] mask, ua, ub, p;
        longint      sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = longint'(ua);
        if (ua[w-1]) sa = sa - (longint'(1) << w);
        sb   = longint'(ub);
        if (ub[w-1]) sb = sb - (longint'(1) << w);
        ed = 1'b0;
        p  = 64'd0;
        case (op)
            2'd0: p = 64'(sa * sb);
            2'd1: p = ua * ub;
            2'd2: begin
                if (ub == 64'd0) begin
                    ed = 1'b1;
                    p  = (ua << w) | mask;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = ((64'(r) & mask) << w) | (64'(q) & mask);
                end
            end
            default: begin
                if (ub == 64'd0) begin
                    ed = 1'b1;
                    p  = (ua << w) | mask;
                end else begin
                    p = (((ua % ub) & mask) << w) | ((ua / ub) & mask);
                end
            end
        endcase
        eh = 32'((p >> w) & mask);
        el = 32'(p & mask);
    endfunction

    task automatic drive(input int w, input logic st, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic hw, input logic lw, input logic [31:0] wd);
        if (w == 32) begin
            if32.start = st; if32.op = op; if32.a = a; if32.b = b;
            if32.hi_wen = hw; if32.lo_wen = lw; if32.wdata = wd;
        end else begin
            if8.start = st; if8.op = op; if8.a = a[7:0]; if8.b = b[7:0];
            if8.hi_wen = hw; if8.lo_wen = lw; if8.wdata = wd[7:0];
        end
    endtask

    task automatic sample(input int w, output logic bz, output logic dn, output logic dz,
                          output logic [31:0] h, output logic [31:0] l);
        if (w == 32) begin
            bz = if32.busy; dn = if32.done; dz = if32.div_by_zero; h = if32.hi; l = if32.lo;
        end else begin
            bz = if8.busy; dn = if8.done; dz = if8.div_by_zero;
            h = {24'd0, if8.hi}; l = {24'd0, if8.lo};
        end
    endtask

    // Launch one operation (called one step after a clock edge), follow it to
    // completion and compare. With disturb set, a stray start and an MTHI are
    // presented mid-operation and must have no effect.
    task automatic run_op(input int w, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit disturb, input string tag);
        logic [31:0] eh, el, h, l;
        logic        ed, bz, dn, dz;
        int          cyc;
        ref_md(w, op, a, b, eh, el, ed);
        drive(w, 1'b1, op, a, b, 1'b0, 1'b0, 32'd0);
        @(posedge clk); #1;
        drive(w, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        sample(w, bz, dn, dz, h, l);
        check_val({tag, "_busy_set"}, 64'(bz), 64'd1);
        check_val({tag, "_done_low"}, 64'(dn), 64'd0);
        cyc = 0;
        while (bz && cyc < 4 * w + 8) begin
            @(posedge clk); #1;
            cyc++;
            sample(w, bz, dn, dz, h, l);
            if (disturb && cyc == 5)
                drive(w, 1'b1, ~op, 32'h0000_0003, 32'h0000_0007, 1'b1, 1'b1, 32'hDEAD_BEEF);
            else if (disturb && cyc == 6)
                drive(w, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        end
        check_val({tag, "_latency"}, 64'(cyc), 64'(w + 1));
        check_val({tag, "_done"}, 64'(dn), 64'd1);
        check_val({tag, "_hi"}, 64'(h), 64'(eh));
        check_val({tag, "_lo"}, 64'(l), 64'(el));
        check_val({tag, "_dbz"}, 64'(dz), 64'(ed));
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'd1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'd1 << (w - 1);
            default: v = $urandom;
        endcase
        if (w == 8) v = v & 32'h0000_00FF;
        return v;
    endfunction

    initial begin
        logic [31:0] h, l;
        logic        bz, dn, dz;
        int          seen;

        drive(32, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        drive(8,  1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sample(32, bz, dn, dz, h, l);
        check_val("rst32_state", {59'd0, bz, dn, dz, |h, |l}, 64'd0);
        sample(8, bz, dn, dz, h, l);
        check_val("rst8_state", {59'd0, bz, dn, dz, |h, |l}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors, issued back-to-back (each start in the prior done cycle).
        run_op(32, 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_m3x5");
        run_op(32, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        run_op(32, 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        run_op(32, 2'd3, 32'h1234_5678, 32'd0, 1'b0, "divu_zero");
        run_op(32, 2'd1, 32'd2, 32'd3, 1'b0, "multu_2x3");
        run_op(32, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
        run_op(32, 2'd2, 32'h8000_0000, 32'd0, 1'b0, "div_neg_zero");

        // MTLO / MTHI while idle.
        drive(32, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        drive(32, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h3C3C_3C3C);
        sample(32, bz, dn, dz, h, l);
        check_val("mtlo_lo", 64'(l), 64'hA5A5_A5A5);
        @(posedge clk); #1;
        drive(32, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        sample(32, bz, dn, dz, h, l);
        check_val("mthi_hi", 64'(h), 64'h3C3C_3C3C);
        check_val("mthi_lo_kept", 64'(l), 64'hA5A5_A5A5);

        // Reset at E10 of a MULT aborts it.
        drive(32, 1'b1, 2'd0, 32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0, 32'd0);
        @(posedge clk); #1;
        drive(32, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sample(32, bz, dn, dz, h, l);
        check_val("rst_mid_busy", 64'(bz), 64'd0);
        check_val("rst_mid_hilo", {h, l}, 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            sample(32, bz, dn, dz, h, l);
            if (dn || bz) seen++;
        end
        check_val("rst_mid_no_done", 64'(seen), 64'd0);

        // WIDTH=8 vectors.
        run_op(8, 2'd0, 32'h80, 32'h80, 1'b0, "w8_mult_m128sq");
        run_op(8, 2'd2, 32'h64, 32'hF9, 1'b0, "w8_div_100_m7");
        run_op(8, 2'd2, 32'h80, 32'hFF, 1'b1, "w8_div_ovf");
        run_op(8, 2'd3, 32'h5A, 32'h00, 1'b0, "w8_divu_zero");

        // Randomized operations with corner-biased operands.
        for (int i = 0; i < 40; i++)
            run_op(32, 2'($urandom_range(0, 3)), pick(32), pick(32), 1'b0, "rnd32");
        for (int i = 0; i < 30; i++)
            run_op(8, 2'($urandom_range(0, 3)), pick(8), pick(8), 1'b0, "rnd8");

        @(posedge clk); #1;
        sample(8, bz, dn, dz, h, l);
        check_val("w8_done_pulse_end", 64'(dn), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit with built-in HI/LO registers, the next generation of the CPU's single-cycle multiply/divide path for the pipelined core. Operands are accepted on a start strobe, the operation runs one bit per clock, and HI/LO update on completion. The unit raises busy so the pipeline stalls any MFHI/MFLO or new MD instruction until done.

## Interface
- WIDTH, 32, operand/HI/LO width; even, ≥ 4
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  launch operation; sampled only when busy=0
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  in  WIDTH  multiplicand / dividend (rs)
- b  in  WIDTH  multiplier / divisor (rt)
- hi_wen  in  1  MTHI write strobe
- lo_wen  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- div_by_zero  out  1  last completed division had b=0

## Operation
- States: IDLE, CALC, FIX. Iteration counter ceil(log2(WIDTH))+1 bits.
- IDLE: start=1 latches op, magnitudes |a|,|b| (signed ops) or raw a,b, result signs; counter←0; →CALC.
- CALC: one radix-2 step per edge. Multiply: shift-add of magnitudes into 2·WIDTH accumulator. Divide: restoring shift-subtract, WIDTH+1-bit partial remainder. After WIDTH steps →FIX.
- FIX: apply sign correction; write HI/LO; →IDLE.
- Multiply: {HI,LO} = full 2·WIDTH product; MULT two's-complement, MULTU unsigned.
- Divide: LO = quotient, HI = remainder. Signed quotient truncates toward zero; remainder takes dividend's sign.
- Divide by zero (b=0): LO = all ones, HI = a (original), div_by_zero←1. Any other completing op clears div_by_zero; multiplies clear it too.
- Signed overflow (a = most negative, b = −1): LO = most negative, HI = 0, no flag.
- hi_wen/lo_wen: honoured only when busy=0; HI/LO ← wdata at the edge. Ignored while busy (pipeline guarantees none are issued).
- start with hi_wen/lo_wen in the same IDLE cycle: MT write applied, operation starts; completion later overwrites both HI and LO.
- start while busy=1: ignored, no queueing.
- Operands a, b, op need only be valid in the start cycle.

## Timing
- Start accepted at edge E0; busy=1 from E0 through E(WIDTH+1).
- CALC at edges E1..E(WIDTH); FIX at E(WIDTH+1).
- At E(WIDTH+1): HI/LO updated, done=1, busy=0 in the following cycle. Latency WIDTH+1 edges (33 at WIDTH=32).
- done high exactly one cycle; a new start may be accepted in that cycle (back-to-back throughput WIDTH+1 cycles per op).
- HI/LO outputs are registered, no bypass; MFHI in done cycle reads new value.
- Reset: state IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0. Reset mid-operation aborts; no done, HI/LO cleared.

## Test plan
- WIDTH=32, MULT a=0xFFFFFFFD (−3), b=5 -> after 33 edges done=1, HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; then DIV a=−7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678, div_by_zero=1; following MULTU 2×3 -> LO=6, HI=0, div_by_zero=0.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0; start pulsed mid-operation and hi_wen during busy -> ignored, results unaffected.
- MTLO wdata=0xA5A5A5A5 in IDLE -> lo=0xA5A5A5A5 next cycle; rst asserted at E10 of a MULT -> busy=0, no done, hi=lo=0.
- WIDTH=8: MULT −128×−128 -> HI=0x40, LO=0x00 after 9 edges; DIV 100/−7 -> LO=0xF2 (−14), HI=0x02.
